avalon_burst_agent_ram: RTL and testbench



---
 rtl/avalon_burst_agent_if.sv | 22 ++
 rtl/avalon_burst_agent_ram.sv | 137 +++++++++++++
 tb/tb_avalon_burst_agent_ram.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_burst_agent_if.sv
// Avalon-MM burst bus between a host (master) and a memory agent (slave).
interface avalon_burst_agent_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [5:0]  burstcount;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, byteenable, read, write, writedata, burstcount,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_burst_agent_ram.sv
// Avalon-MM burst agent backed by a synchronous-read word RAM.
// Fixed-latency pipelined burst reads, byte-enabled burst writes, optional write wait-state injection.
module avalon_burst_agent_ram #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int STALL_EVERY  = 0
) (
  input  logic                clk,
  input  logic                reset,
  avalon_burst_agent_if.slave bus,
  output logic                protocol_error
);
  // state       | meaning
  // IDLE        | ready for a new read or write command
  // WRITE_BURST | accepting write beats 2..N of a burst
  // READ_WAIT   | read latency countdown before the first beat
  // READ_BURST  | returning read beats on consecutive cycles
  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_WAIT, READ_BURST} state_t;

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [5:0]        burst_len;
  logic [5:0]        beat_idx;
  logic [5:0]        lat_cnt;
  logic [5:0]        stall_cnt;
  logic              wait_q;
  logic              rdv_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] cmd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [5:0]        bc_eff;
  logic              wr_acc;
  logic              rd_acc;
  logic              stall_hit;
  logic              unused_addr_bits;

  assign bus.waitrequest   = wait_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.readdata      = rdata_q;

  assign unused_addr_bits = ^{bus.address[31:ADDR_W+2], bus.address[1:0]};

  assign cmd_idx = bus.address[ADDR_W+1:2];
  assign bc_eff  = (bus.burstcount == 6'd0) ? 6'd1 : bus.burstcount;
  assign wr_acc  = !reset && bus.write && !wait_q && (state == IDLE || state == WRITE_BURST);
  assign rd_acc  = !reset && bus.read && !bus.write && !wait_q && (state == IDLE);

  // Stall count spans bursts; the cycle after the Nth accepted write beat is a wait state.
  assign stall_hit = (STALL_EVERY != 0) && wr_acc && (stall_cnt + 6'd1 == 6'(STALL_EVERY));

  assign wr_idx = (state == IDLE) ? cmd_idx : base + ADDR_W'(beat_idx);
  assign rd_idx = (state == READ_WAIT) ? base : base + ADDR_W'(beat_idx + 6'd1);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) mem[wr_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_q         <= 1'b1;
      rdv_q          <= 1'b0;
      rdata_q        <= '0;
      protocol_error <= 1'b0;
      base           <= '0;
      burst_len      <= '0;
      beat_idx       <= '0;
      lat_cnt        <= '0;
      stall_cnt      <= '0;
    end else begin
      wait_q <= stall_hit;
      rdv_q  <= 1'b0;
      if (wr_acc) stall_cnt <= stall_hit ? 6'd0 : stall_cnt + 6'd1;

      case (state)
        IDLE: begin
          if (wr_acc || rd_acc) begin
            if (bus.burstcount == 6'd0 || (bus.read && bus.write)) protocol_error <= 1'b1;
            base      <= cmd_idx;
            burst_len <= bc_eff;
            if (wr_acc) begin
              beat_idx <= 6'd1;
              if (bc_eff != 6'd1) state <= WRITE_BURST;
            end else begin
              lat_cnt <= 6'(READ_LATENCY - 1);
              wait_q  <= 1'b1;
              state   <= READ_WAIT;
            end
          end
        end

        WRITE_BURST: begin
          if (bus.read) protocol_error <= 1'b1;
          if (wr_acc) begin
            if (beat_idx + 6'd1 == burst_len) state <= IDLE;
            else beat_idx <= beat_idx + 6'd1;
          end
        end

        READ_WAIT: begin
          wait_q <= 1'b1;
          if (lat_cnt == 6'd0) begin
            rdata_q  <= mem[rd_idx];
            rdv_q    <= 1'b1;
            beat_idx <= 6'd0;
            state    <= READ_BURST;
          end else begin
            lat_cnt <= lat_cnt - 6'd1;
          end
        end

        READ_BURST: begin
          // beat_idx is the beat currently on readdata; release the bus once the last one has been shown.
          if (beat_idx + 6'd1 == burst_len) begin
            state <= IDLE;
          end else begin
            wait_q   <= 1'b1;
            rdata_q  <= mem[rd_idx];
            rdv_q    <= 1'b1;
            beat_idx <= beat_idx + 6'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_burst_agent_ram.sv
// Directed bench for avalon_burst_agent_ram: vector table for byte enables plus hand-written burst sequences.
module tb_avalon_burst_agent_ram;
  logic clk;
  logic reset;
  logic protocol_error;

  avalon_burst_agent_if bus();

  avalon_burst_agent_ram #(.ADDR_W(10), .READ_LATENCY(2), .STALL_EVERY(3)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] wbuf [32];
  logic [31:0] rbuf [32];
  logic [31:0] wr_hist;
  int          wr_span;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd_addr;
    logic [31:0] init;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // rd_mode: 0 none, 1 read together with beat 1, 2 read raised from beat 2 on
  task automatic do_write(input logic [31:0] addr, input logic [5:0] bc, input logic [3:0] be,
                          input int rd_mode);
    int n, i, g, t, first, last;
    bit acc;
    n = (bc == 6'd0) ? 1 : int'(bc);
    i = 0; g = 0; t = 0; first = 0; last = 0;
    wr_hist = '0;
    @(negedge clk);
    bus.address    = addr;
    bus.burstcount = bc;
    bus.byteenable = be;
    bus.writedata  = wbuf[0];
    bus.write      = 1'b1;
    bus.read       = (rd_mode == 1);
    while (i < n && g < 100) begin
      acc = !bus.waitrequest;
      wr_hist = {wr_hist[30:0], bus.waitrequest};
      if (acc) begin
        if (i == 0) first = t;
        last = t;
      end
      @(negedge clk);
      g++; t++;
      if (acc) begin
        i++;
        if (i < n) bus.writedata = wbuf[i];
        bus.read = (rd_mode == 2);
      end
    end
    bus.write = 1'b0;
    bus.read  = 1'b0;
    wr_span = last - first + 1;
    if (g >= 100) begin
      failures++;
      checks++;
      $display("FAIL write_timeout beats=%0d required=%0d", i, n);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [5:0] bc,
                         output int lat, output int gaps, output bit wr_after);
    int n, g, got;
    bit acc;
    n = (bc == 6'd0) ? 1 : int'(bc);
    g = 0; acc = 1'b0;
    @(negedge clk);
    bus.address    = addr;
    bus.burstcount = bc;
    bus.read       = 1'b1;
    while (!acc && g < 100) begin
      acc = !bus.waitrequest;
      @(negedge clk);
      g++;
    end
    bus.read = 1'b0;
    lat = 0;
    while (!bus.readdatavalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    got = 0; gaps = 0;
    while (got < n && g < 200) begin
      if (bus.readdatavalid) begin
        rbuf[got] = bus.readdata;
        got++;
      end else begin
        gaps++;
      end
      @(negedge clk);
      g++;
    end
    wr_after = !bus.waitrequest && !bus.readdatavalid;
    if (!acc || got < n) begin
      failures++;
      checks++;
      $display("FAIL read_timeout beats=%0d required=%0d", got, n);
    end
  endtask

  task automatic count_rdv(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.readdatavalid) cnt++;
    end
  endtask

  initial begin
    int lat, gaps, cnt, seen, g;
    bit wra, acc;

    vecs[0] = '{32'h20,   32'h20, 32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD};
    vecs[1] = '{32'h24,   32'h24, 32'h11223344, 32'hAABBCCDD, 4'b1010, 32'hAA22CC44};
    vecs[2] = '{32'h28,   32'h28, 32'h11223344, 32'hAABBCCDD, 4'b0000, 32'h11223344};
    vecs[3] = '{32'h2F,   32'h2C, 32'h11223344, 32'hAABBCCDD, 4'b1000, 32'hAA223344};
    vecs[4] = '{32'h1030, 32'h30, 32'h11223344, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD};
    vecs[5] = '{32'h34,   32'h34, 32'h11223344, 32'h000000DD, 4'b0001, 32'h112233DD};

    reset = 1'b1;
    bus.address = '0; bus.byteenable = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.burstcount = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_waitrequest", {31'd0, bus.waitrequest}, 32'd1);
    check("rst_readdatavalid", {31'd0, bus.readdatavalid}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_protocol_error", {31'd0, protocol_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_waitrequest", {31'd0, bus.waitrequest}, 32'd0);

    // single write then single read
    wbuf[0] = 32'hDEADBEEF;
    do_write(32'h10, 6'd1, 4'hF, 0);
    do_read(32'h10, 6'd1, lat, gaps, wra);
    check("single_latency", lat, 32'd2);
    check("single_data", rbuf[0], 32'hDEADBEEF);
    check("single_wait_low_after", {31'd0, wra}, 32'd1);

    // 8-beat burst wrapping at the top of the RAM
    for (int i = 0; i < 8; i++) wbuf[i] = i;
    do_write(32'hFF0, 6'd8, 4'hF, 0);
    do_read(32'hFF0, 6'd8, lat, gaps, wra);
    check("wrap_latency", lat, 32'd2);
    check("wrap_gaps", gaps, 32'd0);
    check("wrap_wait_low_after", {31'd0, wra}, 32'd1);
    for (int i = 0; i < 8; i++) check($sformatf("wrap_beat%0d", i), rbuf[i], i);
    do_read(32'h0, 6'd4, lat, gaps, wra);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_low_word%0d", i), rbuf[i], i + 4);

    // byte-enable vector table
    for (int v = 0; v < 6; v++) begin
      wbuf[0] = vecs[v].init;
      do_write(vecs[v].addr, 6'd1, 4'hF, 0);
      wbuf[0] = vecs[v].wdata;
      do_write(vecs[v].addr, 6'd1, vecs[v].be, 0);
      do_read(vecs[v].rd_addr, 6'd1, lat, gaps, wra);
      check($sformatf("be_vec%0d", v), rbuf[0], vecs[v].exp);
    end
    check("no_err_after_clean_ops", {31'd0, protocol_error}, 32'd0);

    // stall injection every 3 write beats, counted from reset
    do_reset();
    for (int i = 0; i < 7; i++) wbuf[i] = 32'h5000 + i;
    do_write(32'h200, 6'd7, 4'hF, 0);
    check("stall_pattern", {23'd0, wr_hist[8:0]}, 32'b000100010);
    check("stall_span", wr_span, 32'd9);
    do_read(32'h200, 6'd7, lat, gaps, wra);
    for (int i = 0; i < 7; i++) check($sformatf("stall_word%0d", i), rbuf[i], 32'h5000 + i);
    check("stall_no_err", {31'd0, protocol_error}, 32'd0);

    // read and write together in IDLE: write wins, read dropped
    wbuf[0] = 32'hCAFE0001;
    do_write(32'h300, 6'd1, 4'hF, 1);
    count_rdv(8, cnt);
    check("rw_idle_no_rdv", cnt, 32'd0);
    check("rw_idle_err", {31'd0, protocol_error}, 32'd1);
    do_read(32'h300, 6'd1, lat, gaps, wra);
    check("rw_idle_data", rbuf[0], 32'hCAFE0001);
    check("rw_idle_err_sticky", {31'd0, protocol_error}, 32'd1);

    // read raised during a write burst
    do_reset();
    check("err_cleared_by_reset", {31'd0, protocol_error}, 32'd0);
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hB0 + i;
    do_write(32'h310, 6'd3, 4'hF, 2);
    count_rdv(8, cnt);
    check("rd_in_wburst_no_rdv", cnt, 32'd0);
    check("rd_in_wburst_err", {31'd0, protocol_error}, 32'd1);
    do_read(32'h310, 6'd3, lat, gaps, wra);
    for (int i = 0; i < 3; i++) check($sformatf("rd_in_wburst_word%0d", i), rbuf[i], 32'hB0 + i);

    // burstcount 0 behaves as a single beat and flags an error
    do_reset();
    wbuf[0] = 32'h0BC00000;
    do_write(32'h320, 6'd0, 4'hF, 0);
    check("bc0_err", {31'd0, protocol_error}, 32'd1);
    wbuf[0] = 32'h0BC00001;
    do_write(32'h330, 6'd1, 4'hF, 0);
    do_read(32'h320, 6'd1, lat, gaps, wra);
    check("bc0_word", rbuf[0], 32'h0BC00000);
    do_read(32'h324, 6'd1, lat, gaps, wra);
    check("bc0_next_word_untouched", rbuf[0] === 32'h0BC00001 ? 32'd1 : 32'd0, 32'd0);
    do_read(32'h330, 6'd1, lat, gaps, wra);
    check("bc0_followup_write", rbuf[0], 32'h0BC00001);

    // reset on the 2nd beat of a 16-beat read
    do_reset();
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h7700 + i;
    do_write(32'h400, 6'd16, 4'hF, 0);
    @(negedge clk);
    bus.address = 32'h400; bus.burstcount = 6'd16; bus.read = 1'b1;
    g = 0; acc = 1'b0;
    while (!acc && g < 100) begin
      acc = !bus.waitrequest;
      @(negedge clk);
      g++;
    end
    bus.read = 1'b0;
    seen = 0; g = 0;
    while (seen < 2 && g < 50) begin
      if (bus.readdatavalid) seen++;
      if (seen < 2) begin
        @(negedge clk);
        g++;
      end
    end
    check("midrst_saw_two_beats", seen, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rdv_low", {31'd0, bus.readdatavalid}, 32'd0);
    check("midrst_wait_high", {31'd0, bus.waitrequest}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_wait_low_after", {31'd0, bus.waitrequest}, 32'd0);
    count_rdv(20, cnt);
    check("midrst_no_stray_rdv", cnt, 32'd0);
    do_read(32'h400, 6'd16, lat, gaps, wra);
    check("midrst_readback_first", rbuf[0], 32'h7700);
    check("midrst_readback_last", rbuf[15], 32'h770F);
    check("midrst_readback_gaps", gaps, 32'd0);
    do_read(32'h10, 6'd1, lat, gaps, wra);
    check("ram_kept_over_reset", rbuf[0], 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
